// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two issuing units, the arbiter and the shared ALU.
// The slave view belongs to the arbiter; the master view to the surrounding units.
`timescale 1ns/1ps
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_opcode;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_opcode;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic [7:0] rsp0_result;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp1_result;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_result;
  logic       busy;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output alu_opcode, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  alu_opcode, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters, one op in flight.
// Operands are registered onto the ALU, the result is sampled after ALU_LAT cycles.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] opcode_q, opcode_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] result_q, result_d;
  logic       rsp0_valid_q, rsp0_valid_d;
  logic       rsp1_valid_q, rsp1_valid_d;
  logic       busy_q, busy_d;

  logic grant;
  logic idle;
  logic ready0;
  logic ready1;
  logic consumed;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign idle     = (state_q == IDLE);
  assign ready0   = idle && bus.req0_valid && !grant;
  assign ready1   = idle && bus.req1_valid && grant;
  assign consumed = (rsp0_valid_q && bus.rsp0_ready) || (rsp1_valid_q && bus.rsp1_ready);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    opcode_d     = opcode_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (ready0 || ready1) begin
          opcode_d     = grant ? bus.req1_opcode : bus.req0_opcode;
          a_d          = grant ? bus.req1_a      : bus.req0_a;
          b_d          = grant ? bus.req1_b      : bus.req0_b;
          owner_d      = grant;
          last_grant_d = grant;
          cnt_d        = LAT_INIT;
          busy_d       = 1'b1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_d     = bus.alu_result;
          rsp0_valid_d = ~owner_q;
          rsp1_valid_d = owner_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (consumed) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      opcode_q     <= 2'd0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      result_q     <= 8'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      opcode_q     <= opcode_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.busy        = busy_q;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  // The non-owner port reads zero rather than the captured result.
  assign bus.rsp0_result = rsp0_valid_q ? result_q : 8'd0;
  assign bus.rsp1_result = rsp1_valid_q ? result_q : 8'd0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table on an ALU_LAT=1 instance plus
// hand-written multi-cycle sequences, and an ALU_LAT=3 instance for latency/reset.
`timescale 1ns/1ps
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if ifa();
  alu_arbiter_if ifb();

  function automatic logic [7:0] alu_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'b00:   return {4'd0, a} + {4'd0, b};
      2'b01:   return {4'd0, a} - {4'd0, b};
      2'b10:   return {4'd0, a & b};
      default: return 8'(a) * 8'(b);
    endcase
  endfunction

  assign ifa.alu_result = alu_model(ifa.alu_opcode, ifa.alu_a, ifa.alu_b);
  assign ifb.alu_result = alu_model(ifb.alu_opcode, ifb.alu_a, ifb.alu_b);

  alu_arbiter #(.ALU_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  alu_arbiter #(.ALU_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ifa.req0_valid = 0; ifa.req0_opcode = 0; ifa.req0_a = 0; ifa.req0_b = 0;
    ifa.req1_valid = 0; ifa.req1_opcode = 0; ifa.req1_a = 0; ifa.req1_b = 0;
    ifa.rsp0_ready = 1; ifa.rsp1_ready = 1;
    ifb.req0_valid = 0; ifb.req0_opcode = 0; ifb.req0_a = 0; ifb.req0_b = 0;
    ifb.req1_valid = 0; ifb.req1_opcode = 0; ifb.req1_a = 0; ifb.req1_b = 0;
    ifb.rsp0_ready = 1; ifb.rsp1_ready = 1;
  endtask

  task automatic set_req_a(input logic r, input logic v, input logic [1:0] op,
                           input logic [3:0] a, input logic [3:0] b);
    if (r) begin
      ifa.req1_valid = v; ifa.req1_opcode = op; ifa.req1_a = a; ifa.req1_b = b;
    end else begin
      ifa.req0_valid = v; ifa.req0_opcode = op; ifa.req0_a = a; ifa.req0_b = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       r;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  // One complete op on the ALU_LAT=1 instance with an idle other requester.
  task automatic run_op_a(input vec_t v);
    @(negedge clk);
    set_req_a(v.r, 1'b1, v.op, v.a, v.b);
    #1;
    check("vec_ready", v.r ? ifa.req1_ready : ifa.req0_ready, 1);
    check("vec_ready_other", v.r ? ifa.req0_ready : ifa.req1_ready, 0);
    @(negedge clk);
    set_req_a(v.r, 1'b0, 2'd0, 4'd0, 4'd0);
    check("vec_alu_a", ifa.alu_a, v.a);
    check("vec_alu_b", ifa.alu_b, v.b);
    check("vec_alu_op", ifa.alu_opcode, v.op);
    check("vec_busy_c1", ifa.busy, 1);
    check("vec_rsp_early", v.r ? ifa.rsp1_valid : ifa.rsp0_valid, 0);
    @(negedge clk);
    check("vec_rsp_valid", v.r ? ifa.rsp1_valid : ifa.rsp0_valid, 1);
    check("vec_rsp_result", v.r ? ifa.rsp1_result : ifa.rsp0_result, v.exp);
    check("vec_other_valid", v.r ? ifa.rsp0_valid : ifa.rsp1_valid, 0);
    check("vec_other_result", v.r ? ifa.rsp0_result : ifa.rsp1_result, 0);
    @(negedge clk);
    check("vec_busy_done", ifa.busy, 0);
    check("vec_rsp_cleared", v.r ? ifa.rsp1_valid : ifa.rsp0_valid, 0);
  endtask

  logic grants[6];
  int   ng;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 2'b00, 4'd5,  4'd3,  8'd8};
    vecs[1] = '{1'b1, 2'b00, 4'd7,  4'd7,  8'd14};
    vecs[2] = '{1'b0, 2'b01, 4'd9,  4'd4,  8'd5};
    vecs[3] = '{1'b1, 2'b01, 4'd2,  4'd5,  8'hFD};
    vecs[4] = '{1'b0, 2'b10, 4'd12, 4'd10, 8'd8};
    vecs[5] = '{1'b1, 2'b11, 4'd15, 4'd15, 8'd225};
    vecs[6] = '{1'b0, 2'b00, 4'd15, 4'd15, 8'd30};
    vecs[7] = '{1'b1, 2'b11, 4'd0,  4'd9,  8'd0};

    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_busy", ifa.busy, 0);
    check("rst_alu_a", ifa.alu_a, 0);
    check("rst_alu_op", ifa.alu_opcode, 0);
    check("rst_rsp0_valid", ifa.rsp0_valid, 0);
    check("rst_rsp1_valid", ifa.rsp1_valid, 0);
    check("rst_rsp0_result", ifa.rsp0_result, 0);
    check("rst_ready0", ifa.req0_ready, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op_a(vecs[i]);

    // Simultaneous requests straight after reset: req0 wins, req1 at cycle 3.
    do_reset();
    @(negedge clk);
    set_req_a(1'b0, 1'b1, 2'b00, 4'd1, 4'd1);
    set_req_a(1'b1, 1'b1, 2'b00, 4'd2, 4'd2);
    #1;
    check("sim_ready0_c0", ifa.req0_ready, 1);
    check("sim_ready1_c0", ifa.req1_ready, 0);
    @(negedge clk);
    set_req_a(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    #1;
    check("sim_ready1_c1", ifa.req1_ready, 0);
    @(negedge clk);
    check("sim_rsp0_valid", ifa.rsp0_valid, 1);
    check("sim_rsp0_result", ifa.rsp0_result, 8'd2);
    check("sim_ready1_c2", ifa.req1_ready, 0);
    @(negedge clk);
    #1;
    check("sim_ready1_c3", ifa.req1_ready, 1);
    @(negedge clk);
    set_req_a(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    @(negedge clk);
    check("sim_rsp1_valid", ifa.rsp1_valid, 1);
    check("sim_rsp1_result", ifa.rsp1_result, 8'd4);
    @(negedge clk);

    // Fairness: both requesters hold valid; grants must alternate.
    do_reset();
    ng = 0;
    @(negedge clk);
    set_req_a(1'b0, 1'b1, 2'b00, 4'd1, 4'd1);
    set_req_a(1'b1, 1'b1, 2'b00, 4'd2, 4'd2);
    for (int cyc = 0; cyc < 100 && ng < 6; cyc++) begin
      if (cyc != 0) @(negedge clk);
      #1;
      if (ifa.req0_ready && ifa.req1_ready) check("fair_both_ready", 1, 0);
      if (ifa.req0_ready) begin grants[ng] = 1'b0; ng++; end
      else if (ifa.req1_ready) begin grants[ng] = 1'b1; ng++; end
    end
    @(negedge clk);
    set_req_a(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    set_req_a(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    check("fair_grant_count", ng, 6);
    for (int i = 0; i < ng; i++) check("fair_grant_order", grants[i], i % 2);
    repeat (3) @(negedge clk);
    check("fair_drained", ifa.busy, 0);

    // Backpressure on requester 1 while requester 0 waits.
    @(negedge clk);
    ifa.rsp1_ready = 1'b0;
    set_req_a(1'b1, 1'b1, 2'b00, 4'd7, 4'd7);
    #1;
    check("bp_ready1", ifa.req1_ready, 1);
    @(negedge clk);
    set_req_a(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    set_req_a(1'b0, 1'b1, 2'b00, 4'd1, 4'd2);
    #1;
    check("bp_ready0_wait", ifa.req0_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("bp_rsp1_valid", ifa.rsp1_valid, 1);
      check("bp_rsp1_result", ifa.rsp1_result, 8'd14);
      check("bp_busy", ifa.busy, 1);
      check("bp_ready0_resp", ifa.req0_ready, 0);
    end
    ifa.rsp1_ready = 1'b1;
    #1;
    check("bp_ready0_consume", ifa.req0_ready, 0);
    @(negedge clk);
    #1;
    check("bp_rsp1_gone", ifa.rsp1_valid, 0);
    check("bp_ready0_after", ifa.req0_ready, 1);
    @(negedge clk);
    set_req_a(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    @(negedge clk);
    check("bp_rsp0_result", ifa.rsp0_result, 8'd3);
    @(negedge clk);

    // ALU_LAT=3 instance: first response at cycle 4.
    @(negedge clk);
    ifb.req0_valid = 1; ifb.req0_opcode = 2'b00; ifb.req0_a = 4'd9; ifb.req0_b = 4'd6;
    #1;
    check("lat_ready0", ifb.req0_ready, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ifb.req0_valid = 0;
      check("lat_no_rsp", ifb.rsp0_valid, 0);
      check("lat_busy", ifb.busy, 1);
    end
    @(negedge clk);
    check("lat_rsp0_valid_c4", ifb.rsp0_valid, 1);
    check("lat_rsp0_result", ifb.rsp0_result, 8'd15);
    @(negedge clk);
    check("lat_busy_done", ifb.busy, 0);

    // Reset during WAIT on the ALU_LAT=3 instance.
    @(negedge clk);
    ifb.req0_valid = 1; ifb.req0_opcode = 2'b11; ifb.req0_a = 4'd3; ifb.req0_b = 4'd4;
    #1;
    check("rw_accept", ifb.req0_ready, 1);
    @(negedge clk);
    ifb.req0_valid = 0;
    check("rw_busy_before", ifb.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_busy", ifb.busy, 0);
    check("rw_alu_a", ifb.alu_a, 0);
    check("rw_alu_b", ifb.alu_b, 0);
    check("rw_alu_op", ifb.alu_opcode, 0);
    check("rw_rsp0_valid", ifb.rsp0_valid, 0);
    check("rw_rsp0_result", ifb.rsp0_result, 0);
    check("rw_rsp1_valid", ifb.rsp1_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rw_no_rsp", ifb.rsp0_valid, 0);
    end
    @(negedge clk);
    ifb.req0_valid = 1; ifb.req0_opcode = 2'b00; ifb.req0_a = 4'd4; ifb.req0_b = 4'd4;
    ifb.req1_valid = 1; ifb.req1_opcode = 2'b00; ifb.req1_a = 4'd1; ifb.req1_b = 4'd1;
    #1;
    check("rw_tie_ready0", ifb.req0_ready, 1);
    check("rw_tie_ready1", ifb.req1_ready, 0);
    @(negedge clk);
    ifb.req0_valid = 0; ifb.req1_valid = 0;
    repeat (3) @(negedge clk);
    check("rw_rsp0_valid_after", ifb.rsp0_valid, 1);
    check("rw_rsp0_result_after", ifb.rsp0_result, 8'd8);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 4-bit ALU between two requesters. Each requester submits an {opcode, A, B} operation over a valid/ready handshake. The block owns the ALU operand ports, waits a fixed ALU latency, captures the 8-bit result, and returns it on that requester's response channel. It sits between the two issuing units and the ALU instance. Only one operation is in flight at a time.

## Interface
- ALU_LAT, default 1: cycles between operands appearing on alu_* and sampling alu_result; legal range 1..15.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opcode  in  2  requester 0 ALU opcode
- req0_a  in  4  requester 0 operand A
- req0_b  in  4  requester 0 operand B
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_result  out  8  result for requester 0
- rsp1_valid, rsp1_ready, rsp1_result: same as requester 0 response, for requester 1
- alu_opcode  out  2  registered opcode to ALU
- alu_a  out  4  registered operand A to ALU
- alu_b  out  4  registered operand B to ALU
- alu_result  in  8  ALU result, combinational from alu_* ports
- busy  out  1  high whenever state is not IDLE

## Operation
- **Reset values:** all outputs 0. State is IDLE, wait counter 0, owner 0, last_grant = 1, so requester 0 wins the first tie.
- **FSM:** IDLE -> WAIT -> RESP -> IDLE.
- **IDLE, grant selection:**
  - Both valid: grant the requester that is not last_grant.
  - One valid: grant that requester.
- **IDLE, ready signal:**
  - reqN_ready = (state==IDLE) and (grant==N).
  - It is combinational from the current-cycle valid signals and is never asserted to both requesters.
- **IDLE, acceptance (valid & ready):**
  - Register opcode, A and B onto the alu_* ports.
  - Set owner = granted requester and last_grant = owner.
  - Load counter = ALU_LAT and go to WAIT.
- **WAIT:** decrement the counter each cycle. In the cycle the counter equals 1, capture alu_result into the result register and go to RESP.
- **RESP:**
  - rspN_valid = 1 only for N == owner; rspN_result = captured value.
  - On rspN_valid & rspN_ready, go to IDLE.
  - Valid and result hold stable until consumed.
- **Non-owner response port:** rsp_valid is 0 and rsp_result is 0.
- **Operand ports:** alu_* hold their last value in IDLE and RESP; they change only on acceptance.
- **Requester rules:** payload must stay stable while valid is high and ready is low. Dropping valid before ready is allowed; the arbiter keeps no state from it.
- **rsp_ready outside RESP:** ignored.
- **Requests during WAIT/RESP:** ready stays 0. Pending requests are arbitrated at the next IDLE cycle.
- **Reset mid-operation:** the in-flight operation is discarded and no response is issued. All outputs return to reset values immediately (asynchronous).
- **Widths:** result is passed through unmodified at 8 bits. The block performs no arithmetic beyond the 4-bit down-counter.

## Timing
- **Cycle 0:** handshake at IDLE; alu_* update on the closing edge.
- **Cycles 1..ALU_LAT:** WAIT. alu_result is sampled at the edge ending cycle ALU_LAT.
- **Cycle ALU_LAT+1:** first cycle with rsp_valid high.
- **Back-to-back:** if rsp_ready is high in cycle ALU_LAT+1, the next acceptance occurs in cycle ALU_LAT+2. Peak throughput is 1 op per ALU_LAT+2 cycles.
- **busy:** high from cycle 1 through the last RESP cycle.
- **Response backpressure:** each cycle rsp_ready is held low extends RESP by one cycle, with no loss.

## Test plan
- **Single op, ALU_LAT=1.** Bench ALU model: opcode 00 -> A+B. Stimulus: req0 {00, A=5, B=3}. Required: ready high at cycle 0; alu_a=5, alu_b=3 at cycle 1; rsp0_valid with result 8 at cycle 2; rsp1_valid stays 0.
- **Simultaneous requests after reset.** Stimulus: req0 {00,1,1} and req1 {00,2,2}, both valid at cycle 0, rsp ready always high. Required: req0 served first (result 2), then req1 (result 4); req1 accepted at cycle 3.
- **Fairness.** Stimulus: both requesters hold valid continuously for 6 ops. Required: grants alternate 0,1,0,1,0,1; no requester is starved.
- **Backpressure.** Stimulus: req1 {00,7,7}, rsp1_ready low for 4 cycles. Required: rsp1_valid and rsp1_result=14 held stable; busy stays high; req0 ready stays 0 until the cycle after consumption.
- **Latency parameter.** Stimulus: ALU_LAT=3, req0 {00,9,6}. Required: rsp0_valid first at cycle 4 with result 15.
- **Reset mid-WAIT.** Stimulus: rst_n low during WAIT. Required: all outputs 0 immediately; no rsp_valid after release; the next request is granted to req0 on a tie.
